// File: rtl/rv_core_pkg.sv
// Shared core-wide constants and types for the RV32 pipeline front end.
// fetch_entry_t is the {pc, inst} pair carried from fetch into decode.
package rv_core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO with flush, used to buffer fetched words.
// Flush wins over push and pop in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic [W-1:0]               head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop, full;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && !empty_o;
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && !do_pop && full));

endmodule

// File: rtl/fetch_unit.sv
// RV32 instruction fetch: owns the PC, issues in-order imem requests under a
// credit limit, buffers returned words and presents one {pc, inst} per cycle.
module fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_stall,
  input  logic            i_ex_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_f_valid,
  output logic [XLEN-1:0] o_f_pc,
  output logic [XLEN-1:0] o_f_inst
);

  localparam int            CW  = $clog2(FIFO_DEPTH+1);
  localparam logic [CW:0]   CAP = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   fifo_cnt;
  logic            fifo_empty;
  logic            credit_ok, issue, drop, push, pop;
  fetch_entry_t    head, push_ent;

  // Words in flight plus words buffered may never exceed the FIFO size,
  // so every response always has a slot waiting for it.
  assign credit_ok   = ({1'b0, outst_q} + {1'b0, fifo_cnt}) < CAP;
  assign o_imem_req  = rst_n && !i_redirect && credit_ok;
  assign o_imem_addr = fetch_pc_q;
  assign issue       = o_imem_req && i_imem_gnt;

  assign drop = i_imem_rvalid && (discard_q != '0);
  assign push = i_imem_rvalid && (discard_q == '0) && !i_redirect;

  assign o_f_valid = !fifo_empty;
  assign pop       = o_f_valid && !i_stall && !i_ex_stall && !i_redirect;

  assign push_ent.pc   = resp_pc_q;
  assign push_ent.inst = i_imem_rdata;

  assign o_f_pc   = o_f_valid ? head.pc   : resp_pc_q;
  assign o_f_inst = o_f_valid ? head.inst : NOP_INST;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (i_redirect),
    .push_i      (push),
    .push_data_i (push_ent),
    .pop_i       (pop),
    .count_o     (fifo_cnt),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    if (i_redirect) begin
      // Everything still in flight is stale; a response landing now is
      // already accounted for by decrementing before the copy.
      fetch_pc_d = word_align(i_redirect_pc);
      resp_pc_d  = word_align(i_redirect_pc);
      outst_d    = outst_q - CW'(i_imem_rvalid);
      discard_d  = outst_q - CW'(i_imem_rvalid);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)  resp_pc_d  = resp_pc_q + 32'd4;
      if (drop)  discard_d  = discard_q - 1'b1;
      outst_d = outst_q + CW'(issue) - CW'(i_imem_rvalid);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  a_rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_imem_rvalid && outst_q == '0));

  a_discard_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    discard_q <= outst_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order memory model answers grants,
// a reference stream of expected PCs is queued on reset/redirect, and a
// monitor compares every consumed instruction plus hold/issue behaviour.
module tb_fetch_unit;
  import rv_core_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_stall = 1'b0, i_ex_stall = 1'b0, i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0, i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_f_valid;
  logic [31:0] o_f_pc, o_f_inst;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_stall(i_stall), .i_ex_stall(i_ex_stall),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_f_valid(o_f_valid), .o_f_pc(o_f_pc), .o_f_inst(o_f_inst)
  );

  int checks = 0, errors = 0;

  logic [31:0] pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_next = RST_PC, exp_fetch = RST_PC;

  int gnt_pct = 100, rv_pct = 100, stall_pct = 0, ex_pct = 0, redir_pct = 0;
  bit force_stall = 0, force_gnt_off = 0, force_redir = 0;
  logic [31:0] force_tgt = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_restart(input logic [31:0] t);
    exp_q.delete();
    exp_next  = t;
    exp_fetch = t;
  endtask

  // Memory + stimulus driver: all inputs change on the falling edge.
  logic        drv_redir;
  logic [31:0] drv_tgt;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_q.delete();
      i_imem_rvalid = 1'b0;
      i_imem_gnt    = 1'b0;
      i_redirect    = 1'b0;
      i_stall       = 1'b0;
      i_ex_stall    = 1'b0;
      model_restart(RST_PC);
    end else begin
      drv_redir = force_redir || ($urandom_range(99) < redir_pct);
      drv_tgt   = force_tgt;
      if (!force_redir)
        drv_tgt = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15)
                                           : ($urandom & 32'h0000_FFFF);
      i_stall       = force_stall || ($urandom_range(99) < stall_pct);
      i_ex_stall    = ($urandom_range(99) < ex_pct);
      i_imem_gnt    = !force_gnt_off && ($urandom_range(99) < gnt_pct);
      i_imem_rvalid = (pend_q.size() > 0) && ($urandom_range(99) < rv_pct);
      i_imem_rdata  = i_imem_rvalid ? mem_word(pend_q.pop_front()) : $urandom;
      i_redirect    = drv_redir;
      i_redirect_pc = drv_tgt;
      if (drv_redir) model_restart(drv_tgt & 32'hFFFF_FFFC);
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(exp_next);
      exp_next += 32'd4;
    end
    #1;
    if (rst_n && o_imem_req && i_imem_gnt) pend_q.push_back(o_imem_addr);
  end

  // Monitor: checks consumed instructions and cycle-to-cycle behaviour.
  logic        p_hold = 1'b0, p_wait = 1'b0;
  logic [31:0] p_pc, p_inst, p_addr, e_pc;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      p_hold = 1'b0;
      p_wait = 1'b0;
    end else begin
      if (!o_f_valid) chk("idle_nop", o_f_inst, NOP_INST);
      if (p_hold) begin
        chk("hold_valid", 32'(o_f_valid), 32'd1);
        chk("hold_pc", o_f_pc, p_pc);
        chk("hold_inst", o_f_inst, p_inst);
      end
      if (p_wait && !i_redirect) begin
        chk("req_held", 32'(o_imem_req), 32'd1);
        chk("addr_stable", o_imem_addr, p_addr);
      end
      if (i_redirect) chk("redir_no_req", 32'(o_imem_req), 32'd0);
      if (o_imem_req && i_imem_gnt) begin
        chk("fetch_addr", o_imem_addr, exp_fetch);
        exp_fetch += 32'd4;
      end
      if (o_f_valid && !i_stall && !i_ex_stall && !i_redirect) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL model_empty: got pc %h expected none", o_f_pc);
        end else begin
          e_pc = exp_q.pop_front();
          chk("out_pc", o_f_pc, e_pc);
          chk("out_inst", o_f_inst, mem_word(e_pc));
        end
      end
      p_hold = o_f_valid && (i_stall || i_ex_stall) && !i_redirect;
      p_pc   = o_f_pc;
      p_inst = o_f_inst;
      p_wait = o_imem_req && !i_imem_gnt;
      p_addr = o_imem_addr;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   32'(o_imem_req), 32'd0);
    chk({tag, "_addr"},  o_imem_addr, RST_PC);
    chk({tag, "_valid"}, 32'(o_f_valid), 32'd0);
    chk({tag, "_pc"},    o_f_pc, RST_PC);
    chk({tag, "_inst"},  o_f_inst, NOP_INST);
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #3;
      seen = o_f_valid;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: got no valid output expected one within %0d cycles", name, budget);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("rst");

    // Zero-wait stream and first-word latency
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk); #3;
    chk("first_req", 32'(o_imem_req), 32'd1);
    chk("first_addr", o_imem_addr, RST_PC);
    chk("lat_c0_valid", 32'(o_f_valid), 32'd0);
    @(negedge clk); #3 chk("lat_c1_valid", 32'(o_f_valid), 32'd0);
    @(negedge clk); #3;
    chk("lat_c2_valid", 32'(o_f_valid), 32'd1);
    chk("lat_c2_pc", o_f_pc, RST_PC);
    chk("lat_c2_inst", o_f_inst, mem_word(RST_PC));
    repeat (3) @(negedge clk);

    // Stall hold: credits run out, head held
    @(posedge clk); force_stall = 1;
    repeat (3) @(negedge clk);
    #3;
    chk("stall_req_drop", 32'(o_imem_req), 32'd0);
    chk("stall_valid", 32'(o_f_valid), 32'd1);
    @(posedge clk); force_stall = 0;
    repeat (4) @(negedge clk);

    // Redirect with two requests in flight
    @(posedge clk); rv_pct = 0;
    repeat (4) @(negedge clk);
    #3;
    chk("inflight_req", 32'(o_imem_req), 32'd0);
    chk("inflight_valid", 32'(o_f_valid), 32'd0);
    @(posedge clk); force_redir = 1; force_tgt = 32'h100; rv_pct = 100;
    @(posedge clk); force_redir = 0;
    wait_valid("redir_wait", 20);
    chk("redir_pc", o_f_pc, 32'h100);
    chk("redir_inst", o_f_inst, mem_word(32'h100));
    repeat (4) @(negedge clk);

    // Redirect during stall to a misaligned target
    @(posedge clk); force_stall = 1;
    repeat (2) @(posedge clk);
    force_redir = 1; force_tgt = 32'h202;
    @(negedge clk); #3 chk("rds_req", 32'(o_imem_req), 32'd0);
    @(posedge clk); force_redir = 0;
    @(negedge clk); #3;
    chk("rds_valid", 32'(o_f_valid), 32'd0);
    chk("rds_addr", o_imem_addr, 32'h200);
    @(posedge clk); force_stall = 0;
    repeat (4) @(negedge clk);

    // Slow memory: grant withheld for three cycles
    @(posedge clk); force_gnt_off = 1; force_redir = 1; force_tgt = 32'h300;
    @(posedge clk); force_redir = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #3;
      chk("slow_req", 32'(o_imem_req), 32'd1);
      chk("slow_addr", o_imem_addr, 32'h300);
      chk("slow_valid", 32'(o_f_valid), 32'd0);
    end
    @(posedge clk); force_gnt_off = 0;
    wait_valid("slow_wait", 20);
    chk("slow_pc", o_f_pc, 32'h300);

    // Random traffic
    @(posedge clk);
    gnt_pct = 60; rv_pct = 50; stall_pct = 20; ex_pct = 10; redir_pct = 3;
    repeat (1500) @(posedge clk);

    // Asynchronous reset mid-stream
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    gnt_pct = 100; rv_pct = 100; stall_pct = 0; ex_pct = 0; redir_pct = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #3;
    chk("rr_req", 32'(o_imem_req), 32'd1);
    chk("rr_addr", o_imem_addr, RST_PC);
    wait_valid("rr_wait", 10);
    chk("rr_pc", o_f_pc, RST_PC);

    @(posedge clk);
    gnt_pct = 80; rv_pct = 70; stall_pct = 30; ex_pct = 15; redir_pct = 5;
    repeat (1500) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
